gf_mul_scheduler: RTL and testbench

- Control block that shares one bit-serial GF(2^m) multiplier datapath among NREQ requesters (point-add/double sequencer, inversion unit, etc.).
- Arbitrates round-robin and drives the LOAD/CLEAR strobes of the operand, accumulator and result registers.
- Sequences the N-step multiply and returns a one-cycle ACK to the winner.
- Contains no field arithmetic; the datapath stays external.

---
 rtl/gf_mul_sched_pkg.sv | 15 +
 rtl/gf_mul_scheduler_rr_arbiter.sv | 28 ++
 rtl/gf_mul_scheduler.sv | 143 ++++++++++++++
 tb/tb_gf_mul_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_mul_sched_pkg.sv
// Shared types and constants for the GF(2^m) multiplier scheduler.
package gf_mul_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STORE,
    DONE
  } state_e;

  localparam int DEFAULT_N = 233;
  localparam int PERF_W    = 32;

endpackage

// File: rtl/gf_mul_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from last+1, with wrap.
module rr_arbiter
  import gf_mul_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_valid
);

  // Scan farthest-first so the nearest requester after last is the final assignment.
  always_comb begin
    int idx;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        gnt_idx   = IDW'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf_mul_scheduler.sv
// Shares one bit-serial GF(2^m) multiplier among NREQ requesters and sequences LOAD/RUN/STORE/DONE.
// Define GF_MUL_SCHED_PERF_EN to add the saturating PERF_CNT completion counter.
module gf_mul_scheduler
  import gf_mul_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N    = DEFAULT_N,
  parameter int IDW  = $clog2(NREQ),
  parameter int CW   = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ,
  input  logic              ABORT,
  output logic [IDW-1:0]    GNT_ID,
  output logic              BUSY,
  output logic              A_LOAD,
  output logic              B_LOAD,
  output logic              ACC_CLEAR,
  output logic              MUL_STEP,
  output logic [CW-1:0]     BIT_IDX,
  output logic              RES_LOAD,
  output logic [NREQ-1:0]   ACK
`ifdef GF_MUL_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] PERF_CNT
`endif
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            load_q, load_d;
  logic            step_q, step_d;
  logic            res_q, res_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IDW-1:0]  arb_idx;
  logic            arb_valid;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req      (REQ),
    .last     (last_q),
    .gnt_idx  (arb_idx),
    .gnt_valid(arb_valid)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
      res_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      step_q  <= step_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = LOAD;
          gnt_d   = arb_idx;
        end
      end
      LOAD:  state_d = RUN;
      RUN:   if (cnt_q == '0) state_d = STORE;
      STORE: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        last_d  = gnt_q;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything and leaves the round-robin pointer untouched.
    if (ABORT && state_q != IDLE) begin
      state_d = IDLE;
      last_d  = last_q;
    end
    if (state_d == LOAD) begin
      cnt_d = CW'(N - 1);
    end else if (state_q == RUN && state_d == RUN) begin
      cnt_d = cnt_q - CW'(1);
    end else if (state_d == IDLE) begin
      cnt_d = '0;
    end
  end

  // Strobes are decoded from the next state so the registered copies line up with the phase.
  always_comb begin
    busy_d = (state_d != IDLE);
    load_d = (state_d == LOAD);
    step_d = (state_d == RUN);
    res_d  = (state_d == STORE);
    ack_d  = (state_d == DONE) ? (NREQ'(1) << gnt_d) : '0;
  end

  assign GNT_ID    = gnt_q;
  assign BUSY      = busy_q;
  assign A_LOAD    = load_q;
  assign B_LOAD    = load_q;
  assign ACC_CLEAR = load_q;
  assign MUL_STEP  = step_q;
  assign BIT_IDX   = cnt_q;
  assign RES_LOAD  = res_q;
  assign ACK       = ack_q;

`ifdef GF_MUL_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (ack_d != '0 && perf_q != '1) perf_d = perf_q + PERF_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign PERF_CNT = perf_q;
`endif

endmodule

// File: tb/tb_gf_mul_scheduler.sv
// Self-checking bench for gf_mul_scheduler (N=8, NREQ=4): table-driven ops, corner sequences, random traffic.
module tb_gf_mul_scheduler;

  localparam int NREQ = 4;
  localparam int N    = 8;
  localparam int IDW  = 2;
  localparam int CW   = 3;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic [NREQ-1:0] REQ = '0;
  logic            ABORT = 1'b0;
  logic [IDW-1:0]  GNT_ID;
  logic            BUSY, A_LOAD, B_LOAD, ACC_CLEAR, MUL_STEP, RES_LOAD;
  logic [CW-1:0]   BIT_IDX;
  logic [NREQ-1:0] ACK;
`ifdef GF_MUL_SCHED_PERF_EN
  logic [31:0]     PERF_CNT;
`endif

  gf_mul_scheduler #(.NREQ(NREQ), .N(N)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .ABORT    (ABORT),
    .GNT_ID   (GNT_ID),
    .BUSY     (BUSY),
    .A_LOAD   (A_LOAD),
    .B_LOAD   (B_LOAD),
    .ACC_CLEAR(ACC_CLEAR),
    .MUL_STEP (MUL_STEP),
    .BIT_IDX  (BIT_IDX),
    .RES_LOAD (RES_LOAD),
    .ACK      (ACK)
`ifdef GF_MUL_SCHED_PERF_EN
    ,
    .PERF_CNT (PERF_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: position within an operation (0=load, 1..N=steps, N+1=store, N+2=ack).
  bit m_busy = 0;
  int m_pos  = 0;
  int m_gnt  = 0;
  int m_last = NREQ - 1;
  longint m_perf = 0;

  typedef struct {
    logic [NREQ-1:0] req;
    int              expGnt;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rrPick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit ackNow();
    return m_busy && (m_pos == N + 2);
  endfunction

  task automatic modelReset();
    m_busy = 0;
    m_pos  = 0;
    m_gnt  = 0;
    m_last = NREQ - 1;
    m_perf = 0;
  endtask

  task automatic modelStep(input logic [NREQ-1:0] r, input logic ab);
    int g;
    if (m_busy) begin
      if (ab) begin
        m_busy = 0;
      end else if (m_pos == N + 2) begin
        m_busy = 0;
        m_last = m_gnt;
      end else begin
        m_pos++;
        if (m_pos == N + 2 && m_perf < 64'hFFFF_FFFF) m_perf++;
      end
    end else begin
      g = rrPick(r, m_last);
      if (g >= 0) begin
        m_busy = 1;
        m_pos  = 0;
        m_gnt  = g;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [NREQ-1:0]  eAck;
    logic             eLoad, eStep, eRes;
    int               eIdx;
    logic [5+NREQ:0]  act, exp;
    eAck = '0; eLoad = 0; eStep = 0; eRes = 0; eIdx = 0;
    if (m_busy) begin
      if (m_pos == 0) begin
        eLoad = 1; eIdx = N - 1;
      end else if (m_pos <= N) begin
        eStep = 1; eIdx = N - m_pos;
      end else if (m_pos == N + 1) begin
        eRes = 1;
      end else begin
        eAck = NREQ'(1) << m_gnt;
      end
    end
    act = {BUSY, A_LOAD, B_LOAD, ACC_CLEAR, MUL_STEP, RES_LOAD, ACK};
    exp = {m_busy, eLoad, eLoad, eLoad, eStep, eRes, eAck};
    check({tag, ".strobes"}, 64'(act), 64'(exp));
    if (m_busy) check({tag, ".gnt_idx"}, 64'({GNT_ID, BIT_IDX}), 64'({IDW'(m_gnt), CW'(eIdx)}));
`ifdef GF_MUL_SCHED_PERF_EN
    check({tag, ".perf"}, 64'(PERF_CNT), 64'(m_perf));
`endif
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic ab, input string tag);
    REQ   = r;
    ABORT = ab;
    modelStep(r, ab);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput(tag);
  endtask

  task automatic resetDut();
    @(negedge CLK);
    RST_N = 1'b0;
    REQ   = '0;
    ABORT = 1'b0;
    modelReset();
    repeat (2) @(negedge CLK);
    checkOutput("reset");
    check("reset.gnt", 64'(GNT_ID), 64'd0);
    check("reset.bitidx", 64'(BIT_IDX), 64'd0);
    RST_N = 1'b1;
  endtask

  // One operation from IDLE: REQ held until ACK, then dropped for one IDLE cycle.
  task automatic runOp(input logic [NREQ-1:0] r, input int expGnt, input logic ab0, input string tag);
    int n;
    applyStimulus(r, ab0, tag);
    check({tag, ".grant"}, 64'(GNT_ID), 64'(expGnt));
    n = 0;
    while (!ackNow() && n < N + 5) begin
      applyStimulus(r, 1'b0, tag);
      n++;
    end
    if (!ackNow()) check({tag, ".timeout"}, 64'd1, 64'd0);
    check({tag, ".ack"}, 64'(ACK), 64'(NREQ'(1) << expGnt));
    applyStimulus('0, 1'b0, tag);
  endtask

  initial begin
    int order[4];
    int k;
    logic [NREQ-1:0] want;

    tbl[0] = '{4'b0001, 0};
    tbl[1] = '{4'b1111, 1};
    tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3};
    tbl[4] = '{4'b0101, 0};
    tbl[5] = '{4'b0101, 2};
    tbl[6] = '{4'b0101, 0};
    tbl[7] = '{4'b1000, 3};
    tbl[8] = '{4'b0110, 1};
    tbl[9] = '{4'b1001, 3};

    resetDut();
    for (int i = 0; i < 10; i++) runOp(tbl[i].req, tbl[i].expGnt, 1'b0, "table");

    // All four requesting, each dropping after its own ACK.
    resetDut();
    order = '{0, 1, 2, 3};
    want = 4'b1111;
    k = 0;
    for (int c = 0; c < 4 * (N + 4) + 8 && (want != 0 || m_busy); c++) begin
      applyStimulus(want, 1'b0, "all4");
      if (m_busy && m_pos == 0 && k < 4) begin
        check("all4.order", 64'(GNT_ID), 64'(order[k]));
        k++;
      end
      if (ackNow()) want[m_gnt] = 1'b0;
    end
    check("all4.count", 64'(k), 64'd4);

    // 0101 held continuously: grants must alternate.
    resetDut();
    order = '{0, 2, 0, 2};
    k = 0;
    for (int c = 0; c < 4 * (N + 4); c++) begin
      applyStimulus(4'b0101, 1'b0, "alt");
      if (m_busy && m_pos == 0 && k < 4) begin
        check("alt.order", 64'(GNT_ID), 64'(order[k]));
        k++;
      end
    end
    check("alt.count", 64'(k), 64'd4);
    while (m_busy) applyStimulus('0, 1'b0, "alt.drain");

    // Abort on the 3rd RUN cycle of requester 1, then 1 must win again over 0.
    resetDut();
    runOp(4'b0001, 0, 1'b0, "pre_abort");
    applyStimulus(4'b0010, 1'b0, "abort");
    check("abort.gnt", 64'(GNT_ID), 64'd1);
    while (m_busy && m_pos < 3) applyStimulus(4'b0010, 1'b0, "abort");
    check("abort.bitidx", 64'(BIT_IDX), 64'(N - 3));
    applyStimulus(4'b0010, 1'b1, "abort.pulse");
    check("abort.busy", 64'({BUSY, RES_LOAD, ACK}), 64'd0);
    runOp(4'b0011, 1, 1'b0, "post_abort");
    runOp(4'b0100, 2, 1'b1, "idle_abort");

    // Asynchronous reset in the middle of RUN.
    applyStimulus(4'b1000, 1'b0, "midrst");
    while (m_busy && m_pos < 4) applyStimulus(4'b1000, 1'b0, "midrst");
    #2 RST_N = 1'b0;
    modelReset();
    #1;
    check("midrst.async", 64'({BUSY, A_LOAD, B_LOAD, ACC_CLEAR, MUL_STEP, RES_LOAD, ACK, GNT_ID, BIT_IDX}), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    REQ   = '0;
    runOp(4'b1000, 3, 1'b0, "after_rst");

`ifdef GF_MUL_SCHED_PERF_EN
    resetDut();
    for (int i = 0; i < 5; i++) runOp(4'b0001, 0, 1'b0, "perf");
    applyStimulus(4'b0010, 1'b0, "perf.abort");
    applyStimulus(4'b0010, 1'b0, "perf.abort");
    applyStimulus(4'b0010, 1'b1, "perf.abort");
    applyStimulus('0, 1'b0, "perf.idle");
    check("perf.total", 64'(PERF_CNT), 64'd5);
`endif

    // Random traffic against the reference model.
    resetDut();
    want = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!want[i] && $urandom_range(7) == 0) want[i] = 1'b1;
      applyStimulus(want, ($urandom_range(39) == 0), "random");
      if (ackNow()) want[m_gnt] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
